// File: rtl/div_pkg.sv
// Shared state encoding, flag bundle and sizing helper for the sequential divider.
package div_pkg;

  localparam int DIV_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic div_by_zero;
    logic overflow;
  } div_flags_t;

  // Iteration counter width; a 1-bit floor keeps degenerate widths legal.
  function automatic int div_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/cla_nbit.sv
// Purpose: n-bit carry-lookahead adder, 4-bit lookahead groups chained on group carries.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module cla_nbit #(
  parameter int n = 17
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout
);

  localparam int NBLK = (n + 3) / 4;

  logic [n-1:0]  g;
  logic [n-1:0]  p;
  logic [n:0]    c;
  logic [NBLK:0] bc;
  logic          gg;
  logic          gp;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    bc = '0;
    gg = 1'b0;
    gp = 1'b0;
    bc[0] = cin;
    // Group generate/propagate; the last group may be narrower than 4 bits.
    for (int k = 0; k < NBLK; k++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int j = 0; j < 4; j++) begin
        if (4 * k + j < n) begin
          gg = g[4*k+j] | (p[4*k+j] & gg);
          gp = gp & p[4*k+j];
        end
      end
      bc[k+1] = gg | (gp & bc[k]);
    end
    c[0] = bc[0];
    for (int i = 1; i < n; i++) begin
      if (i % 4 == 0) begin
        c[i] = bc[i/4];
      end else begin
        c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
    end
    c[n] = bc[NBLK];
    sum  = p ^ c[n-1:0];
    cout = c[n];
  end

endmodule

// File: rtl/div32x16_seq.sv
// Purpose: unsigned restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock.
// Latency: result valid WIDTH edges after the accept edge; zero divisor or overflow valid right after the accept edge.
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module div32x16_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int               CNT_W    = div_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e        state_q, state_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  div_flags_t        flags_q, flags_d;
  logic              out_valid_q, out_valid_d;

  logic [WIDTH-1:0]  dvd_hi;
  logic [WIDTH-1:0]  dvd_lo;
  logic [WIDTH:0]    t;
  logic [WIDTH:0]    sub_b;
  logic [WIDTH:0]    diff;
  logic              sub_cout;
  logic              no_borrow;

  assign dvd_hi = dividend[2*WIDTH-1:WIDTH];
  assign dvd_lo = dividend[WIDTH-1:0];

  // Trial subtraction t - divisor as t + ~divisor + 1; carry-out high means no borrow.
  assign t     = {r_q, q_q[WIDTH-1]};
  assign sub_b = ~{1'b0, dvs_q};

  cla_nbit #(
    .n (WIDTH + 1)
  ) u_trial_sub (
    .a    (t),
    .b    (sub_b),
    .cin  (1'b1),
    .sum  (diff),
    .cout (sub_cout)
  );

  // With r < divisor, a successful subtract always leaves diff[WIDTH] clear.
  assign no_borrow = sub_cout & ~diff[WIDTH];

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            state_d             = DIV_DONE;
            quo_d               = '1;
            rem_d               = '0;
            flags_d.div_by_zero = 1'b1;
            flags_d.overflow    = 1'b0;
            out_valid_d         = 1'b1;
          end else if (dvd_hi >= divisor) begin
            state_d             = DIV_DONE;
            quo_d               = '1;
            rem_d               = '0;
            flags_d.div_by_zero = 1'b0;
            flags_d.overflow    = 1'b1;
            out_valid_d         = 1'b1;
          end else begin
            state_d = DIV_BUSY;
            r_d     = dvd_hi;
            q_d     = dvd_lo;
            dvs_d   = divisor;
            cnt_d   = '0;
          end
        end
      end

      DIV_BUSY: begin
        r_d   = no_borrow ? diff[WIDTH-1:0] : t[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], no_borrow};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d             = DIV_DONE;
          quo_d               = q_d;
          rem_d               = r_d;
          flags_d.div_by_zero = 1'b0;
          flags_d.overflow    = 1'b0;
          out_valid_d         = 1'b1;
        end
      end

      DIV_DONE: begin
        if (out_ready) begin
          state_d     = DIV_IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = DIV_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DIV_IDLE;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = (state_q == DIV_IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = flags_q.div_by_zero;
  assign overflow    = flags_q.overflow;

endmodule

// File: tb/tb_div32x16_seq.sv
// Scoreboard bench for div32x16_seq: issued ops push an arithmetic expectation, a monitor pops on each result handshake.
module tb_div32x16_seq;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dbz;
    logic         ovf;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  logic rand_rdy  = 1'b0;
  logic force_rdy = 1'b1;
  logic rnd_bit   = 1'b0;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  assign out_ready = rand_rdy ? rnd_bit : force_rdy;

  div32x16_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with the error cases decided on the true quotient.
  function automatic exp_t model(input logic [2*W-1:0] dd, input logic [W-1:0] ds);
    exp_t e;
    if (ds == 0) begin
      e.quo = '1; e.rem = '0; e.dbz = 1'b1; e.ovf = 1'b0;
    end else if ((dd / ds) > 32'h0000_FFFF) begin
      e.quo = '1; e.rem = '0; e.dbz = 1'b0; e.ovf = 1'b1;
    end else begin
      e.quo = W'(dd / ds); e.rem = W'(dd % ds); e.dbz = 1'b0; e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Monitor: compare on every result handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got quotient %0h with nothing outstanding", quotient);
        end else begin
          e = exp_q.pop_front();
          chk("quotient", quotient, e.quo);
          chk("remainder", remainder, e.rem);
          chk("div_by_zero", div_by_zero, e.dbz);
          chk("overflow", overflow, e.ovf);
        end
      end
    end
  end

  // Returns #1 after the accepting edge.
  task automatic issue(input logic [2*W-1:0] dd, input logic [W-1:0] ds);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("issue_in_ready", in_ready, 1);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = ds;
    exp_q.push_back(model(dd, ds));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_op(input logic [2*W-1:0] dd, input logic [W-1:0] ds);
    int  k;
    int  n;
    bit  err;
    issue(dd, ds);
    chk("in_ready_after_accept", in_ready, 0);
    err = (ds == 0) || ((dd / ds) > 32'h0000_FFFF);
    wait_valid(k);
    chk("latency", k, err ? 0 : 16);
    n = 0;
    while (out_valid && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("result_consumed", out_valid, 0);
    chk("in_ready_after_result", in_ready, 1);
    if (!rand_rdy && force_rdy) chk("handshake_edges", n, 1);
  endtask

  initial begin
    exp_t           bp;
    int             k;
    int             sel;
    logic [2*W-1:0] dd;
    logic [W-1:0]   ds;

    rst_n    = 1'b1;
    in_valid = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_flags", {div_by_zero, overflow}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'd1000, 16'd7);
    run_op(32'h1234_5678, 16'd0);
    run_op(32'h0007_0000, 16'd7);
    run_op(32'h0006_FFFF, 16'd7);
    run_op(32'hFFFE_0001, 16'hFFFF);
    run_op(32'h0000_FFFF, 16'd1);

    // Result held under backpressure; in_valid pulses must not start anything.
    force_rdy = 1'b0;
    bp = model(32'd123456, 16'd789);
    issue(32'd123456, 16'd789);
    wait_valid(k);
    chk("bp_latency", k, 16);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dividend = $urandom;
      divisor  = (i % 2 == 0) ? 16'd0 : 16'd3;
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", {quotient, remainder, div_by_zero, overflow}, {bp.quo, bp.rem, bp.dbz, bp.ovf});
    end
    in_valid  = 1'b0;
    force_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_quotient_kept", quotient, bp.quo);
    run_op(32'd999_999, 16'd1000);

    // Asynchronous reset after the 8th busy step.
    issue(32'd5000, 16'd3);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_flags", {div_by_zero, overflow}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'd100, 16'd10);

    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 15);
      ds  = W'($urandom);
      if (sel == 0) ds = '0;
      if (sel == 1 || ds == 0) dd = $urandom;
      else dd = {W'($urandom % ds), W'($urandom)};
      if (sel == 2) dd[2*W-1:W] = ds;
      if (sel == 3 && ds != 0) dd[2*W-1:W] = ds - 16'd1;
      run_op(dd, ds);
    end
    rand_rdy = 1'b0;

    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("scoreboard_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/div32x16_seq.md
# div32x16_seq

Iterative unsigned restoring divider: 2·W-bit dividend by W-bit divisor, giving a W-bit quotient and a W-bit remainder. It is the inverse datapath of the 16x16 multiplier in the MAC. It serves the normalisation and scale-back paths that must undo a product. One quotient bit is resolved per clock, with valid/ready handshakes on both sides and one operation in flight.

## Interface
- `WIDTH`, default 16: divisor, quotient and remainder width. The dividend is 2·WIDTH.
- `clk` input 1: the single clock. Every flop is rising-edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operands are valid.
- `in_ready` output 1: the block can accept operands. High only in IDLE.
- `dividend` input 2·WIDTH: unsigned dividend.
- `divisor` input WIDTH: unsigned divisor.
- `out_valid` output 1: the result is valid.
- `out_ready` input 1: the consumer accepts the result.
- `quotient` output WIDTH: registered quotient.
- `remainder` output WIDTH: registered remainder.
- `div_by_zero` output 1: the divisor was 0.
- `overflow` output 1: the quotient does not fit in WIDTH bits.

## Operation
- FSM states are IDLE, BUSY and DONE.
- **Accept:** a transfer happens on the edge where `in_valid && in_ready` (this is edge E0).
- **Error checks at E0:**
  - `divisor==0`: go to DONE with `div_by_zero=1`, `quotient=all-ones`, `remainder=0`.
  - Otherwise, if `dividend[2W-1:W] >= divisor`: go to DONE with `overflow=1`, `quotient=all-ones`, `remainder=0`.
  - `div_by_zero` takes priority, so the two flags are never both set.
- **Normal load at E0:**
  - Partial remainder `r` (W bits) takes `dividend[2W-1:W]`.
  - Shift register `q` (W bits) takes `dividend[W-1:0]`.
  - Iteration counter clears to 0, and the FSM goes to BUSY.
- **One BUSY step per edge:**
  - Form `t = {r, q[W-1]}` (W+1 bits) and `d = t - {1'b0, divisor}`.
  - No borrow: `r <= d[W-1:0]`, `q <= {q[W-2:0], 1}`.
  - Borrow: `r <= t[W-1:0]`, `q <= {q[W-2:0], 0}`.
  - The invariant `r < divisor` always holds, so `r` fits in W bits.
- **Finish:** after WIDTH steps (counter = WIDTH-1 on the last step), go to DONE. `quotient=q`, `remainder=r`, both flags 0.
- **DONE:**
  - `out_valid=1`, and all outputs are held stable until `out_ready`.
  - On the edge where `out_valid && out_ready`, go to IDLE and drop `out_valid`.
  - `quotient`, `remainder` and the flags keep their last values.
- **Input while not IDLE:** `in_valid` is ignored in BUSY and DONE. There is no overlap of operations, and the operands are captured only at E0.
- **Reset:** asynchronous and effective mid-operation. On the next edge after release the block is in IDLE with no residual state.

## Timing
- **Reset values:**
  - State is IDLE, so `in_ready=1`.
  - `out_valid=0`, `quotient=0`, `remainder=0`, `div_by_zero=0`, `overflow=0`.
  - Internal `r`, `q` and the counter are 0.
- **Normal latency:** `out_valid` rises after edge E_WIDTH, which is E16 at the default width. That is 16 edges after the accepting edge.
- **Error latency:** `out_valid` rises after E0 (1 edge).
- **Throughput:** at most one operation per WIDTH+2 cycles with `out_ready` tied high.
  - The result handshake happens at E_WIDTH+1.
  - `in_ready` returns after that edge.
- All outputs are registered, except `in_ready`, which is decoded from the state register.
- There is no combinational path from `out_ready` or `in_valid` to any output.

## Structure
- **Shared package `div_pkg`:**
  - State encodings `DIV_IDLE=2'd0`, `DIV_BUSY=2'd1`, `DIV_DONE=2'd2`.
  - `DIV_W_DEFAULT=16`.
- **Sub-module:** the existing `cla_nbit` carry-lookahead adder with `n=WIDTH+1`, used as the trial subtractor.
  - Inputs are `t` and `~{1'b0, divisor}` with carry-in 1.
  - Carry-out = 1 means no borrow.
- **Counter:** `$clog2(WIDTH)` bits.

## Test plan
- **Basic division:** dividend 32'd1000, divisor 16'd7 -> quotient 142, remainder 6, flags 0. `out_valid` first high after E16.
- **Divide by zero:** dividend 32'h1234_5678, divisor 0 -> `div_by_zero=1`, quotient 16'hFFFF, remainder 0. `out_valid` after E0.
- **Overflow boundary:**
  - dividend 32'h0007_0000, divisor 7 -> `overflow=1`, quotient 16'hFFFF, remainder 0.
  - dividend 32'h0006_FFFF, divisor 7 -> quotient 16'hFFFF, remainder 6, no overflow.
- **Maximum operands:** dividend 32'hFFFE_0001, divisor 16'hFFFF -> quotient 16'hFFFF, remainder 0. Then dividend 32'hFFFF, divisor 1 -> quotient 16'hFFFF, remainder 0.
- **Backpressure:**
  - Hold `out_ready=0` for 5 cycles in DONE -> outputs stable, `in_ready=0`, and `in_valid` pulses are ignored.
  - Raise `out_ready` -> handshake, then `in_ready=1` the next cycle, and the next operand pair completes correctly.
- **Reset mid-operation:** assert `rst_n=0` after the 8th BUSY step -> all outputs go to reset values immediately. After release, 100/10 gives quotient 10, remainder 0.
